rr_resource_arbiter: RTL and testbench

//   Shares one datapath resource among NUM_REQ requesters using round-robin arbitration.
//   A granted requester keeps the resource while it holds req, up to MAX_HOLD cycles.

---
 rtl/rr_resource_arbiter.sv | 143 ++++++++++++++
 tb/tb_rr_resource_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter sharing one resource among NUM_REQ requesters.
// An owner keeps the grant while requesting, and is rotated out after MAX_HOLD cycles if anyone else waits.
module rr_resource_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       preempt
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int SW  = IDW + 1;
  localparam int HW  = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);
  localparam logic [SW-1:0]  NUM_W    = SW'(NUM_REQ);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [HW-1:0]  hold_cnt;

  logic [SW-1:0]      pick_any;
  logic [SW-1:0]      pick_oth;
  logic               owner_req;
  logic               do_grant;
  logic               do_idle;
  logic               do_inc;
  logic               do_pre;
  logic [IDW-1:0]     grant_idx;
  logic [NUM_REQ-1:0] grant_vec;
  logic [IDW-1:0]     next_ptr;

  // Circular search from start; returns {found, index}, optionally skipping one index.
  function automatic logic [SW-1:0] pick(
    input logic [NUM_REQ-1:0] r,
    input logic [IDW-1:0]     start,
    input logic               excl_en,
    input logic [IDW-1:0]     excl
  );
    logic [SW-1:0]  sum;
    logic [IDW-1:0] idx;
    logic           found;
    logic [IDW-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, start} + SW'(k);
      if (sum >= NUM_W) sum = sum - NUM_W;
      idx = sum[IDW-1:0];
      if (!found && r[idx] && !(excl_en && (idx == excl))) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  always_comb begin
    pick_any  = pick(req, ptr, 1'b0, '0);
    pick_oth  = pick(req, ptr, 1'b1, gnt_id);
    owner_req = req[gnt_id];
  end

  // A release with another requester pending always wins over expiry, so preempt stays low.
  always_comb begin
    do_grant  = 1'b0;
    do_idle   = 1'b0;
    do_inc    = 1'b0;
    do_pre    = 1'b0;
    grant_idx = '0;
    case (state)
      IDLE: begin
        if (pick_any[IDW]) begin
          do_grant  = 1'b1;
          grant_idx = pick_any[IDW-1:0];
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if (pick_oth[IDW]) begin
            do_grant  = 1'b1;
            grant_idx = pick_oth[IDW-1:0];
          end else begin
            do_idle = 1'b1;
          end
        end else if (hold_cnt < HOLD_MAX) begin
          do_inc = 1'b1;
        end else if (pick_oth[IDW]) begin
          do_grant  = 1'b1;
          do_pre    = 1'b1;
          grant_idx = pick_oth[IDW-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    grant_vec            = '0;
    grant_vec[grant_idx] = 1'b1;
    next_ptr             = (grant_idx == LAST_ID) ? '0 : grant_idx + IDW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      preempt <= do_pre;
      if (do_grant) begin
        state    <= GRANT;
        gnt      <= grant_vec;
        gnt_id   <= grant_idx;
        busy     <= 1'b1;
        hold_cnt <= HW'(1);
        ptr      <= next_ptr;
      end else if (do_idle) begin
        state    <= IDLE;
        gnt      <= '0;
        busy     <= 1'b0;
        hold_cnt <= '0;
      end else if (do_inc) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed bench for rr_resource_arbiter (NUM_REQ=4, MAX_HOLD=8): vector table plus multi-cycle sequences.
module tb_rr_resource_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       pre;
    string      name;
  } vec_t;

  vec_t vecs[12];

  rr_resource_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assert property (@(posedge clk) $onehot0(gnt))
    else $error("[TB] gnt not onehot0: %b", gnt);
  assert property (@(posedge clk) busy == (|gnt))
    else $error("[TB] busy disagrees with gnt: busy=%b gnt=%b", busy, gnt);

  task automatic applyStimulus(input logic r, input logic [3:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] eid,
                             input logic eb, input logic ep);
    checks++;
    if (gnt !== eg || busy !== eb || preempt !== ep || (eb && gnt_id !== eid)) begin
      errors++;
      $display("[TB] FAIL %s: got gnt=%b id=%0d busy=%b preempt=%b, want gnt=%b id=%0d busy=%b preempt=%b",
               name, gnt, gnt_id, busy, preempt, eg, eid, eb, ep);
    end
  endtask

  task automatic checkHold(input string name, input int exp);
    checks++;
    if (int'(dut.hold_cnt) != exp) begin
      errors++;
      $display("[TB] FAIL %s: got hold_cnt=%0d, want %0d", name, dut.hold_cnt, exp);
    end
  endtask

  initial begin
    logic [3:0] one;
    int         o;
    one = 4'b0001;
    rst = 1'b1;
    req = 4'b0000;

    // Reset with all requesting, first grant, early release handover, idle/re-grant, non-owner noise.
    vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_hold_a"};
    vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_hold_b"};
    vecs[2]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_hold_c"};
    vecs[3]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, "first_grant"};
    vecs[4]  = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, "keep_0_a"};
    vecs[5]  = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, "keep_0_b"};
    vecs[6]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "release_to_1"};
    vecs[7]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "release_idle"};
    vecs[8]  = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, "idle_grant_ptr2"};
    vecs[9]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, "keep_3"};
    vecs[10] = '{1'b0, 4'b1110, 4'b1000, 2'd3, 1'b1, 1'b0, "nonowner_noise"};
    vecs[11] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "release_idle_2"};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req);
      checkOutput(vecs[i].name, vecs[i].gnt, vecs[i].id, vecs[i].busy, vecs[i].pre);
    end

    // Lone requester 2 for 20 cycles: no preemption, hold count saturates.
    applyStimulus(1'b1, 4'b0000);
    checkOutput("t2_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      applyStimulus(1'b0, 4'b0100);
      checkOutput("t2_lone_owner", 4'b0100, 2'd2, 1'b1, 1'b0);
      checkHold("t2_hold_cnt", (n < 8) ? n : 8);
    end

    // Everyone requesting: owners 0,1,2,3,0 for 8 cycles each, preempt at each handover.
    applyStimulus(1'b1, 4'b0000);
    checkOutput("t3_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'b0, 4'b1111);
      o = (n / 8) % 4;
      checkOutput("t3_rotation", one << o, 2'(o), 1'b1, (n % 8 == 0) && (n > 0));
    end

    // Reset while requester 2 owns the resource; next grant restarts at index 0.
    applyStimulus(1'b1, 4'b0000);
    checkOutput("t5_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int n = 0; n < 17; n++) begin
      applyStimulus(1'b0, 4'b1111);
      o = (n / 8) % 4;
      checkOutput("t5_rotation", one << o, 2'(o), 1'b1, (n % 8 == 0) && (n > 0));
    end
    applyStimulus(1'b1, 4'b1111);
    checkOutput("t5_mid_grant_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1111);
    checkOutput("t5_regrant_from_0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Owner 0 releases exactly when its hold expires with 3 pending: a release, not a preempt.
    applyStimulus(1'b1, 4'b0000);
    checkOutput("t6_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      applyStimulus(1'b0, 4'b1001);
      checkOutput("t6_owner_0", 4'b0001, 2'd0, 1'b1, 1'b0);
      checkHold("t6_hold_cnt", n);
    end
    applyStimulus(1'b0, 4'b1000);
    checkOutput("t6_release_at_max", 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b1000);
    checkOutput("t6_after_release", 4'b1000, 2'd3, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
